// File: rtl/sync_debounce_pkg.sv
// Shared constants for the sync_debounce slice.
//   EV_FALL / EV_RISE           : encoding of ev_rising for falling / rising events
//   SYNC_STAGES_MIN / _MAX      : legal range of the synchroniser depth
//   sync_stages_legal()         : range check used at elaboration
package sync_debounce_pkg;

  localparam logic EV_FALL = 1'b0;
  localparam logic EV_RISE = 1'b1;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  function automatic logic sync_stages_legal(input int unsigned n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/sync_debounce_sync_chain.sv
// falsepath_anchor: a named buffer marking the asynchronous crossing point, so
//   timing constraints can cut the path into the first synchroniser flop.
//   i : asynchronous input    o : same level, unregistered
// sync_chain: SYNC_STAGES flops in series behind one falsepath_anchor.
//   clk     : sampling clock (rising edge)
//   rst     : asynchronous active-high reset, whole chain -> RESET_VAL
//   i_async : asynchronous level
//   sync_q  : last stage of the chain
module falsepath_anchor (
  input  logic i,
  output logic o
);
  assign o = i;
endmodule

module sync_chain
  import sync_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic sync_q
);

  if (!sync_stages_legal(SYNC_STAGES)) begin : g_illegal_stages
    $error("sync_chain: SYNC_STAGES must be within 2..4");
  end

  logic                   anchored;
  logic [SYNC_STAGES-1:0] stage_d;
  logic [SYNC_STAGES-1:0] stage_q;

  falsepath_anchor u_anchor (
    .i (i_async),
    .o (anchored)
  );

  always_comb begin
    stage_d = {stage_q[SYNC_STAGES-2:0], anchored};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign sync_q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: synchronises an asynchronous level, optionally filters it with
// a stability counter, and reports edges as pulses and as a one-entry event.
// Build option: define SYNC_DEBOUNCE_FILTER_EN to enable the counter filter;
// without it level follows the synchronised input every cycle.
//   clk           : sole clock, rising edge
//   rst           : asynchronous active-high reset
//   i_async       : asynchronous external level
//   filter_cycles : stability cycles required before level changes (quasi-static)
//   level         : filtered, synchronised level
//   rise / fall   : one-cycle pulses coincident with the level change
//   ev_valid / ev_ready / ev_rising : one-entry edge event, valid/ready handshake
//   ovf           : sticky, set when an edge is dropped because the event is held
//   ovf_clr       : synchronous clear of ovf (a concurrent set wins)
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_W    = 4,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_async,
  input  logic [FILTER_W-1:0] filter_cycles,
  output logic                level,
  output logic                rise,
  output logic                fall,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic                ev_rising,
  output logic                ovf,
  input  logic                ovf_clr
);

  logic sync_q;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (RESET_VAL)
  ) u_sync_chain (
    .clk     (clk),
    .rst     (rst),
    .i_async (i_async),
    .sync_q  (sync_q)
  );

  logic level_d,     level_q;
  logic rise_d,      rise_q;
  logic fall_d,      fall_q;
  logic ev_valid_d,  ev_valid_q;
  logic ev_rising_d, ev_rising_q;
  logic ovf_d,       ovf_q;
  logic edge_seen;

`ifdef SYNC_DEBOUNCE_FILTER_EN
  logic [FILTER_W-1:0] cnt_d, cnt_q;

  // cnt only advances while below filter_cycles, so it cannot wrap; the >=
  // also catches filter_cycles being lowered beneath a running count.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= filter_cycles) begin
      level_d = sync_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + FILTER_W'(1);
    end
  end
`else
  logic unused_filter_cycles;
  assign unused_filter_cycles = ^filter_cycles;

  always_comb begin
    level_d = sync_q;
  end
`endif

  // Edges are decoded from the registered pulses, so the event is loaded in
  // the cycle after rise/fall and can be compared against ev_ready then.
  always_comb begin
    rise_d      = level_d & ~level_q;
    fall_d      = ~level_d & level_q;
    edge_seen   = rise_q | fall_q;
    ev_valid_d  = ev_valid_q;
    ev_rising_d = ev_rising_q;
    ovf_d       = ovf_q & ~ovf_clr;
    if (edge_seen) begin
      if (!ev_valid_q || ev_ready) begin
        ev_valid_d  = 1'b1;
        ev_rising_d = rise_q ? EV_RISE : EV_FALL;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q     <= RESET_VAL;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      ev_valid_q  <= 1'b0;
      ev_rising_q <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef SYNC_DEBOUNCE_FILTER_EN
      cnt_q       <= '0;
`endif
    end else begin
      level_q     <= level_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      ev_valid_q  <= ev_valid_d;
      ev_rising_q <= ev_rising_d;
      ovf_q       <= ovf_d;
`ifdef SYNC_DEBOUNCE_FILTER_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign level     = level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign ev_valid  = ev_valid_q;
  assign ev_rising = ev_rising_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce (SYNC_STAGES=2, FILTER_W=4, RESET_VAL=0).
// Filter-specific sequences run only when SYNC_DEBOUNCE_FILTER_EN is defined;
// the shared sequences use filter_cycles=0, which behaves identically in both
// builds.
module tb_sync_debounce;

  logic       clk;
  logic       rst;
  logic       i_async;
  logic [3:0] filter_cycles;
  logic       level;
  logic       rise;
  logic       fall;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_rising;
  logic       ovf;
  logic       ovf_clr;

  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned n_rise;
  int unsigned n_fall;

  sync_debounce #(
    .SYNC_STAGES (2),
    .FILTER_W    (4),
    .RESET_VAL   (1'b0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_async       (i_async),
    .filter_cycles (filter_cycles),
    .level         (level),
    .rise          (rise),
    .fall          (fall),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_rising     (ev_rising),
    .ovf           (ovf),
    .ovf_clr       (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later; tallies output pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rise) n_rise++;
    if (fall) n_fall++;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_rise = 0; n_fall = 0;
    rst = 1'b1; i_async = 1'b0; filter_cycles = 4'd0; ev_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    check("rst_level", level, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_rising", ev_rising, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;

    // Unfiltered latency: level follows on the 3rd edge after the change.
    i_async = 1'b1;
    tick(); tick();
    check("lat_edge2_level", level, 0);
    tick();
    check("lat_edge3_level", level, 1);
    check("lat_edge3_rise", rise, 1);
    check("lat_edge3_fall", fall, 0);
    tick();
    check("lat_edge4_rise", rise, 0);
    check("ev1_valid", ev_valid, 1);
    check("ev1_rising", ev_rising, 1);

    // Held event with ev_ready low: second edge dropped, ovf set.
    i_async = 1'b0;
    tick(); tick(); tick();
    check("drop_fall", fall, 1);
    check("drop_level", level, 0);
    tick();
    check("drop_ovf", ovf, 1);
    check("drop_ev_valid", ev_valid, 1);
    check("drop_ev_rising", ev_rising, 1);
    i_async = 1'b1;
    tick(); tick(); tick();
    check("third_rise", rise, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_set_and_clr", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", ovf, 0);
    check("held_ev_rising", ev_rising, 1);
    ev_ready = 1'b1;
    tick();
    check("ev_drain", ev_valid, 0);

    // ev_ready high: an edge on the transfer cycle replaces the event.
    i_async = 1'b0;
    tick();
    i_async = 1'b1;
    tick(); tick();
    check("pulse_fall", fall, 1);
    check("pulse_level", level, 0);
    tick();
    check("pulse_rise", rise, 1);
    check("pulse_ev_valid", ev_valid, 1);
    check("pulse_ev_fall", ev_rising, 0);
    tick();
    check("replace_ev_valid", ev_valid, 1);
    check("replace_ev_rising", ev_rising, 1);
    check("replace_ovf", ovf, 0);
    tick();
    check("replace_drain", ev_valid, 0);

    // Reset mid-transition with a pending event.
    ev_ready = 1'b0;
    i_async = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_fall", fall, 1);
    tick();
    check("pre_rst_ev_valid", ev_valid, 1);
    i_async = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("rst_async_ev_valid", ev_valid, 0);
    check("rst_async_level", level, 0);
    tick();
    rst = 1'b0;
    n_rise = 0;
    tick(); tick();
    check("post_rst_edge2_level", level, 0);
    tick();
    check("post_rst_edge3_level", level, 1);
    check("post_rst_rise", rise, 1);
    tick();
    check("post_rst_ev_valid", ev_valid, 1);
    check("post_rst_ev_rising", ev_rising, 1);
    check("post_rst_one_rise", n_rise, 1);

    // Reset while level is high, released with i_async low: no pulses.
    rst = 1'b1;
    i_async = 1'b0;
    #1;
    check("rst_hi_level", level, 0);
    check("rst_hi_ev_valid", ev_valid, 0);
    tick();
    rst = 1'b0;
    n_rise = 0; n_fall = 0;
    repeat (5) tick();
    check("quiet_rise_count", n_rise, 0);
    check("quiet_fall_count", n_fall, 0);
    check("quiet_level", level, 0);
    ev_ready = 1'b1;

`ifdef SYNC_DEBOUNCE_FILTER_EN
    // Glitch of exactly filter_cycles synchronised cycles is rejected.
    filter_cycles = 4'd3;
    n_rise = 0;
    i_async = 1'b1;
    repeat (3) tick();
    i_async = 1'b0;
    repeat (8) tick();
    check("glitch_level", level, 0);
    check("glitch_rise_count", n_rise, 0);
    check("glitch_ev_valid", ev_valid, 0);

    // filter_cycles=3: level changes on edge 2+1+3 = 6.
    n_fall = 0;
    i_async = 1'b1;
    repeat (5) tick();
    check("f3_edge5_level", level, 0);
    tick();
    check("f3_edge6_level", level, 1);
    check("f3_edge6_rise", rise, 1);
    check("f3_fall_count", n_fall, 0);

    // filter_cycles lowered 15 -> 2 while cnt = 8.
    filter_cycles = 4'd15;
    i_async = 1'b0;
    repeat (10) tick();
    check("f15_cnt8_level", level, 1);
    filter_cycles = 4'd2;
    tick();
    check("lowered_level", level, 0);
    check("lowered_fall", fall, 1);
`else
    // filter_cycles ignored: latency stays 3 even at 15.
    filter_cycles = 4'd15;
    i_async = 1'b1;
    tick(); tick();
    check("nofilt_edge2_level", level, 0);
    tick();
    check("nofilt_edge3_level", level, 1);
    check("nofilt_edge3_rise", rise, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchroniser flops (legal 2..4).
REQ-002 SHALL have parameter FILTER_W, default 4, width of the debounce counter and filter_cycles.
REQ-003 SHALL have parameter RESET_VAL, default 1'b0, reset value of the whole sync chain and of level.
REQ-004 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_async  input  1  asynchronous external level.
REQ-007 SHALL have port filter_cycles  input  FILTER_W  stability cycles required before level changes; quasi-static.
REQ-008 SHALL have port level  output  1  filtered, synchronised level.
REQ-009 SHALL have port rise / fall  output  1 each  one-cycle pulses, coincident with the level change.
REQ-010 SHALL have port ev_valid / ev_ready / ev_rising  out / in / out  1 each  one-entry edge event (valid/ready).
REQ-011 SHALL have port ovf  output  1  sticky flag: event dropped.
REQ-012 SHALL have port ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-013 i_async SHALL pass through one falsepath_anchor instance before the first sync flop; no other logic precedes it.
REQ-014 Sync chain SHALL be SYNC_STAGES flops in series; sync_q = last stage.
REQ-015 Each cycle: if sync_q == level then cnt <= 0; else if cnt >= filter_cycles then level <= sync_q, cnt <= 0; else cnt <= cnt + 1.
REQ-016 Latency from a stable i_async change to level = SYNC_STAGES + 1 + filter_cycles clocks; filter_cycles = 0 gives SYNC_STAGES + 1.
REQ-017 Any sync_q return to level before the threshold SHALL clear cnt; pulses shorter than filter_cycles + 1 sync'd cycles never reach level.
REQ-018 cnt SHALL never wrap; the >= comparison handles filter_cycles lowered below a live cnt (level changes next cycle).
REQ-019 rise/fall SHALL be registered, asserted exactly in the cycle level first shows the new value, mutually exclusive.
REQ-020 On an edge: if !ev_valid or ev_ready, load event (ev_valid <= 1, ev_rising <= rise); a valid && ready transfer in the same cycle is replaced, not lost.
REQ-021 If ev_valid && !ev_ready on an edge, the new edge SHALL be dropped, held event unchanged, ovf <= 1.
REQ-022 ev_valid SHALL clear on ev_valid && ev_ready with no concurrent edge; ev_rising stable while ev_valid && !ev_ready.
REQ-023 ovf_clr SHALL clear ovf; simultaneous set and clear SHALL leave ovf = 1.

Reset
REQ-024 While rst: sync chain = RESET_VAL, level = RESET_VAL, cnt = 0, rise = fall = 0, ev_valid = 0, ev_rising = 0, ovf = 0.
REQ-025 Reset assertion mid-count or with a pending event SHALL discard both; no edge SHALL be reported for the reset-induced value of level.
REQ-026 After deassertion, a held i_async != RESET_VAL SHALL produce one ordinary edge after REQ-016 latency.

Configuration
REQ-027 Macro SYNC_DEBOUNCE_FILTER_EN defined: counter filter per REQ-015..018.
REQ-028 Macro undefined: no cnt, filter_cycles ignored, level <= sync_q every cycle (latency SYNC_STAGES + 1); all other behaviour unchanged.

Structure
REQ-029 Shared package/header SHALL hold localparams EV_FALL = 1'b0, EV_RISE = 1'b1 and the SYNC_STAGES legal range for parameter checks.
REQ-030 Sync chain SHALL be a sub-module sync_chain (parameters SYNC_STAGES, RESET_VAL), containing the falsepath_anchor instance, for reuse.
REQ-031 Illegal SYNC_STAGES SHALL fail elaboration.

Verification
REQ-032 filter_cycles = 3, i_async 0->1 held: level and rise rise exactly 2 + 1 + 3 = 6 clocks after the first sampling edge; fall stays 0.
REQ-033 filter_cycles = 3, i_async high for 3 clocks then low: level stays 0, no rise, no event.
REQ-034 ev_ready = 0, two edges (rise then fall): event holds ev_rising = 1, ovf = 1; ovf_clr pulse coincident with a third edge leaves ovf = 1.
REQ-035 ev_ready = 1 permanently, edge on the transfer cycle: new event loaded, ev_valid stays 1, no ovf.
REQ-036 filter_cycles changed 15 -> 2 while cnt = 8: level changes next clock.
REQ-037 Macro undefined, filter_cycles = 15: latency 3 clocks; rst asserted mid-transition: all outputs 0 immediately, no spurious pulse after release with i_async = 0.
